seg_display_capture: RTL and testbench

Receive-side monitor for the team's multiplexed two-digit seven-segment display bus. Samples segment lines A–G together with SegSel, debounces each digit phase, decodes the segment pattern back to BCD and reassembles a 0–99 binary value. It sits on the bench or in a self-check path, downstream of the display driver, and reports what the display is actually showing.

---
 rtl/seg_display_capture.sv | 153 +++++++++++++++
 tb/tb_seg_display_capture.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/seg_display_capture.sv
// seg_display_capture
//   Monitors a multiplexed two-digit seven-segment bus. It debounces each
//   digit phase, decodes the segment pattern to BCD and reassembles a
//   0-99 value.
// Parameters
//   STABLE_CYCLES : number of identical consecutive samples needed to accept
//                   a digit (2..255)
//   ACTIVE_LOW    : 1 = segment inputs are active-low
// Ports
//   Clk, Rst      : clock and synchronous active-high reset
//   A..G          : segment lines (A top, G middle)
//   SegSel        : 1 = tens digit phase, 0 = ones digit phase
//   Tens, Ones    : last committed BCD digits
//   Value         : Tens*10 + Ones
//   Valid         : a complete frame has been committed at least once
//   Changed       : one-cycle pulse when a commit changes Value (or is the first)
//   Err           : one-cycle pulse when a stable pattern is not a legal digit
module seg_display_capture #(
  parameter int unsigned STABLE_CYCLES = 4,
  parameter bit          ACTIVE_LOW    = 1'b0
) (
  input  logic       Clk,
  input  logic       Rst,
  input  logic       A,
  input  logic       B,
  input  logic       C,
  input  logic       D,
  input  logic       E,
  input  logic       F,
  input  logic       G,
  input  logic       SegSel,
  output logic [3:0] Tens,
  output logic [3:0] Ones,
  output logic [6:0] Value,
  output logic       Valid,
  output logic       Changed,
  output logic       Err
);

  typedef enum logic [1:0] {EMPTY, T_ONLY, O_ONLY, COMMIT} state_e;

  localparam logic [7:0] RUN_MAX = 8'(STABLE_CYCLES);
  localparam logic [6:0] SEG_INV = {7{ACTIVE_LOW}};

  logic [7:0] samp_d, samp_q;
  logic [7:0] run_d, run_q;
  logic       accept_d, acc_q;
  state_e     state_q, stage_state_d;
  logic [3:0] t_tens_q, t_ones_q;
  logic [3:0] tens_q, ones_q;
  logic [6:0] value_d, value_q;
  logic       valid_q, chg_q, err_q;
  logic [3:0] dec_digit;
  logic       dec_legal, dec_blank;

  always_comb begin
    samp_d   = {SegSel, {A, B, C, D, E, F, G} ^ SEG_INV};
    run_d    = 8'd1;
    accept_d = 1'b0;
    if (samp_d == samp_q) begin
      run_d    = (run_q == RUN_MAX) ? run_q : run_q + 8'd1;
      accept_d = (run_q == RUN_MAX - 8'd1);
    end
  end

  // Decode always looks at samp_q: on the accept edge samp_d equals samp_q,
  // and on the following (staging) edge samp_q still holds that same pattern.
  always_comb begin
    dec_digit = 4'd0;
    dec_legal = 1'b1;
    dec_blank = 1'b0;
    case (samp_q[6:0])
      7'h7E:   dec_digit = 4'd0;
      7'h30:   dec_digit = 4'd1;
      7'h6D:   dec_digit = 4'd2;
      7'h79:   dec_digit = 4'd3;
      7'h33:   dec_digit = 4'd4;
      7'h5B:   dec_digit = 4'd5;
      7'h5F:   dec_digit = 4'd6;
      7'h70:   dec_digit = 4'd7;
      7'h7F:   dec_digit = 4'd8;
      7'h7B:   dec_digit = 4'd9;
      7'h00: begin
        dec_legal = 1'b0;
        dec_blank = 1'b1;
      end
      default: dec_legal = 1'b0;
    endcase
  end

  // Next frame-assembly state for a non-blank accept.
  always_comb begin
    stage_state_d = state_q;
    if (dec_legal) begin
      if (samp_q[7]) begin
        stage_state_d = (state_q == O_ONLY) ? COMMIT : T_ONLY;
      end else begin
        stage_state_d = (state_q == T_ONLY) ? COMMIT : O_ONLY;
      end
    end else if (samp_q[7] && state_q == T_ONLY) begin
      stage_state_d = EMPTY;
    end else if (!samp_q[7] && state_q == O_ONLY) begin
      stage_state_d = EMPTY;
    end
  end

  always_comb begin
    value_d = ({3'b000, t_tens_q} << 3) + ({3'b000, t_tens_q} << 1) + {3'b000, t_ones_q};
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      samp_q   <= '0;
      run_q    <= '0;
      acc_q    <= 1'b0;
      state_q  <= EMPTY;
      t_tens_q <= '0;
      t_ones_q <= '0;
      tens_q   <= '0;
      ones_q   <= '0;
      value_q  <= '0;
      valid_q  <= 1'b0;
      chg_q    <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      samp_q <= samp_d;
      run_q  <= run_d;
      acc_q  <= accept_d;
      err_q  <= accept_d && !dec_blank && !dec_legal;
      chg_q  <= 1'b0;
      if (state_q == COMMIT) begin
        tens_q  <= t_tens_q;
        ones_q  <= t_ones_q;
        value_q <= value_d;
        valid_q <= 1'b1;
        chg_q   <= !valid_q || (value_d != value_q);
        state_q <= EMPTY;
      end else if (acc_q && !dec_blank) begin
        if (dec_legal && samp_q[7])  t_tens_q <= dec_digit;
        if (dec_legal && !samp_q[7]) t_ones_q <= dec_digit;
        state_q <= stage_state_d;
      end
    end
  end

  assign Tens    = tens_q;
  assign Ones    = ones_q;
  assign Value   = value_q;
  assign Valid   = valid_q;
  assign Changed = chg_q;
  assign Err     = err_q;

endmodule

// File: tb/tb_seg_display_capture.sv
// Testbench for seg_display_capture: directed scenarios plus randomized
// phases, every cycle compared against a reference model that works on the
// history of sampled patterns and frame-level bookkeeping.
module tb_seg_display_capture;

  localparam int unsigned S  = 4;
  localparam bit          AL = 1'b0;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       a = 1'b0, b = 1'b0, c = 1'b0, d = 1'b0, e = 1'b0, f = 1'b0, g = 1'b0;
  logic       sel = 1'b0;
  logic [3:0] tens, ones;
  logic [6:0] value;
  logic       valid, changed, err;

  seg_display_capture #(
    .STABLE_CYCLES(S),
    .ACTIVE_LOW   (AL)
  ) dut (
    .Clk    (clk),
    .Rst    (rst),
    .A      (a),
    .B      (b),
    .C      (c),
    .D      (d),
    .E      (e),
    .F      (f),
    .G      (g),
    .SegSel (sel),
    .Tens   (tens),
    .Ones   (ones),
    .Value  (value),
    .Valid  (valid),
    .Changed(changed),
    .Err    (err)
  );

  always #5 clk = ~clk;

  // Segment patterns {A..G} for digits 0..9.
  logic [6:0] seg_tbl [10] = '{7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33,
                               7'h5B, 7'h5F, 7'h70, 7'h7F, 7'h7B};

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Reference model state.
  logic [7:0]  hist [$];
  bit          got_t, got_o;
  int unsigned stg_t, stg_o, pend_t, pend_o;
  int          cyc = 0;
  int          commit_at = -1;
  int unsigned e_t, e_o, e_v;
  bit          e_val, e_chg, e_err;
  int unsigned chg_seen, err_seen;

  function automatic int decode_model(input logic [6:0] p);
    for (int i = 0; i < 10; i++) if (seg_tbl[i] == p) return i;
    return -1;
  endfunction

  task automatic model_edge(input logic r, input logic s, input logic [6:0] segs);
    int          dg;
    int unsigned nv;
    bit          same;
    int          n;
    cyc++;
    e_chg = 1'b0;
    e_err = 1'b0;
    if (r) begin
      hist.delete();
      got_t = 0; got_o = 0;
      e_t = 0; e_o = 0; e_v = 0; e_val = 0;
      commit_at = -1;
      return;
    end
    if (commit_at == cyc) begin
      nv    = pend_t * 10 + pend_o;
      e_chg = !e_val || (nv != e_v);
      e_t   = pend_t;
      e_o   = pend_o;
      e_v   = nv;
      e_val = 1'b1;
    end
    hist.push_back({s, segs});
    if (hist.size() > S + 1) void'(hist.pop_front());
    n = hist.size();
    if (n >= S) begin
      same = 1'b1;
      for (int i = 0; i < S; i++) if (hist[n-1-i] != hist[n-1]) same = 1'b0;
      if (same && (n == S || hist[0] != hist[n-1]) && segs != 7'h00) begin
        dg = decode_model(segs);
        if (dg < 0) begin
          e_err = 1'b1;
          if (s) got_t = 0; else got_o = 0;
        end else begin
          if (s) begin stg_t = dg; got_t = 1; end
          else   begin stg_o = dg; got_o = 1; end
          if (got_t && got_o) begin
            pend_t = stg_t;
            pend_o = stg_o;
            commit_at = cyc + 2;
            got_t = 0;
            got_o = 0;
          end
        end
      end
    end
  endtask

  task automatic step(input logic r, input logic s, input logic [6:0] segs);
    @(negedge clk);
    rst = r;
    sel = s;
    {a, b, c, d, e, f, g} = AL ? ~segs : segs;
    @(posedge clk);
    #1;
    model_edge(r, s, segs);
    check("tens",    tens,    e_t);
    check("ones",    ones,    e_o);
    check("value",   value,   e_v);
    check("valid",   valid,   e_val);
    check("changed", changed, e_chg);
    check("err",     err,     e_err);
    chg_seen += changed;
    err_seen += err;
  endtask

  task automatic hold(input logic r, input logic s, input logic [6:0] segs, input int unsigned n);
    for (int unsigned i = 0; i < n; i++) step(r, s, segs);
  endtask

  task automatic frame(input int unsigned t, input int unsigned o);
    hold(0, 1, seg_tbl[t], S);
    hold(0, 0, seg_tbl[o], S);
    hold(0, 0, 7'h00, 3);
  endtask

  int unsigned kind, len;
  logic        rs;
  logic [6:0]  pat;

  initial begin
    // Reset hold with random segments.
    for (int i = 0; i < 3; i++) step(1, 1'($urandom_range(0, 1)), 7'($urandom));
    check("reset_valid", valid, 0);
    check("reset_value", value, 0);

    // First frame 4/2 with Changed timing checked by the model.
    chg_seen = 0;
    frame(4, 2);
    check("f42_value", value, 42);
    check("f42_valid", valid, 1);
    check("f42_chg_count", chg_seen, 1);

    // Repeat the same frame: no Changed.
    chg_seen = 0;
    frame(4, 2);
    frame(4, 2);
    check("repeat_value", value, 42);
    check("repeat_chg_count", chg_seen, 0);
    frame(4, 3);
    check("f43_value", value, 43);
    check("f43_chg_count", chg_seen, 1);

    // Debounce: a short "7" must not be accepted.
    err_seen = 0;
    hold(0, 1, seg_tbl[7], S - 1);
    hold(0, 1, seg_tbl[1], S);
    hold(0, 0, seg_tbl[0], S);
    hold(0, 0, 7'h00, 3);
    check("deb_value", value, 10);
    check("deb_err_count", err_seen, 0);

    // Illegal pattern A+G on tens phase.
    err_seen = 0;
    chg_seen = 0;
    hold(0, 1, 7'h41, S);
    hold(0, 0, 7'h00, 3);
    check("illegal_err_count", err_seen, 1);
    check("illegal_chg_count", chg_seen, 0);
    frame(9, 9);
    check("f99_value", value, 99);

    // Ones first, long blank, then tens.
    err_seen = 0;
    hold(0, 0, seg_tbl[5], S);
    hold(0, 0, 7'h00, 6);
    hold(0, 1, seg_tbl[0], S);
    hold(0, 0, 7'h00, 3);
    check("order_value", value, 5);
    check("order_err_count", err_seen, 0);

    // Reset mid-frame discards the staged tens digit.
    chg_seen = 0;
    hold(0, 1, seg_tbl[8], S);
    step(1, 1, seg_tbl[8]);
    hold(0, 0, seg_tbl[3], S);
    hold(0, 0, 7'h00, 4);
    check("midrst_valid", valid, 0);
    check("midrst_chg_count", chg_seen, 0);

    // Randomized phases including glitches, blanks, illegal patterns and resets.
    for (int p = 0; p < 300; p++) begin
      kind = $urandom_range(0, 29);
      rs   = 1'($urandom_range(0, 1));
      len  = $urandom_range(1, S + 3);
      if (kind == 0) begin
        step(1, rs, 7'($urandom));
      end else begin
        if (kind <= 2)      pat = 7'h00;
        else if (kind <= 4) pat = 7'($urandom);
        else                pat = seg_tbl[$urandom_range(0, 9)];
        hold(0, rs, pat, len);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
